// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 signed max-pooling over a raster-scan feature map.
// One line of partial row-maxima is held, so no frame store is needed.
module maxpool_2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 24,
    parameter int IMG_H      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] pool_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int BD = IMG_W / 2;
    localparam int BW = (BD > 2) ? $clog2(BD) : 1;

    // Signed maximum; on a tie the shared value comes back unchanged.
    function automatic logic [DATA_WIDTH-1:0] smax(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] m;
        if ($signed(a) > $signed(b)) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_h_max;
    logic [DATA_WIDTH-1:0] r_pool;
    logic                  r_valid;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_line_buf [BD];

    logic [BW-1:0]         w_buf_idx;
    logic [DATA_WIDTH-1:0] w_pair_max;
    logic [DATA_WIDTH-1:0] w_buf_rd;
    logic                  w_last_col;
    logic                  w_last_row;

    assign w_buf_idx  = BW'(r_col >> 1);
    assign w_buf_rd   = r_line_buf[w_buf_idx];
    assign w_pair_max = smax(r_h_max, data_in);
    assign w_last_col = (r_col == CW'(IMG_W - 1));
    assign w_last_row = (r_row == RW'(IMG_H - 1));

    // Line buffer of top-row pair maxima; written on even rows before any odd-row read.
    always_ff @(posedge clk) begin
        if (valid_in && r_col[0] && !r_row[0]) begin
            r_line_buf[w_buf_idx] <= w_pair_max;
        end
    end

    // Raster counters, horizontal max, and registered pooled outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_h_max <= '0;
            r_pool  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (valid_in) begin
                if (w_last_col) begin
                    r_col <= '0;
                    if (w_last_row) begin
                        r_row <= '0;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end

                if (!r_col[0]) begin
                    r_h_max <= data_in;
                end else if (r_row[0]) begin
                    // Bottom-right pixel closes the window: combine with the stored top pair.
                    r_pool  <= smax(w_buf_rd, w_pair_max);
                    r_valid <= 1'b1;
                    r_done  <= w_last_col && w_last_row;
                end
            end
        end
    end

    assign pool_out   = r_pool;
    assign valid_out  = r_valid;
    assign frame_done = r_done;

endmodule
